// File: rtl/spram_frame_reader.sv
// spram_frame_reader
//   Reads one frame of NUM_LEDS 24-bit pixels (two 16-bit SPRAM words each)
//   and presents them in order on a valid/ready stream for the WS2812 driver.
//   Frames start on `start` or when the auto-refresh counter saturates.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   start       single-cycle frame request (ignored while busy)
//   base_addr   word address of pixel 0, sampled at frame start
//   spram_addr  registered SPRAM read address
//   spram_dout  SPRAM data out (one-cycle read latency)
//   pix_data    pixel {G,R,B}
//   pix_valid   pix_data is valid
//   pix_ready   downstream accepts the pixel
//   pix_last    current pixel is the last of the frame (qualified by pix_valid)
//   busy        a frame is in progress
//   frame_done  single-cycle pulse after the last pixel is accepted
module spram_frame_reader #(
  parameter int NUM_LEDS       = 144,
  parameter int ADDR_W         = 14,
  parameter int REFRESH_CYCLES = 720000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] spram_addr,
  input  logic [15:0]       spram_dout,
  output logic [23:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [REF_W-1:0] REF_MAX  = (REFRESH_CYCLES > 0) ? REF_W'(REFRESH_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    CAP,
    PRESENT
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] pix_addr;   // word-0 address of the current pixel
  logic [ADDR_W-1:0] next_addr;
  logic [REF_W-1:0]  ref_cnt;
  logic              refresh_hit;
  logic              launch;
  logic              accept;
  logic              unused_hi;

  // Word 1 upper byte carries no colour data.
  assign unused_hi = ^spram_dout[15:8];

  always_comb begin
    refresh_hit = (REFRESH_CYCLES != 0) && (ref_cnt == REF_MAX);
    launch      = (state == IDLE) && (start || refresh_hit);
    accept      = (state == PRESENT) && pix_valid && pix_ready;
    // base + 2*idx is tracked incrementally instead of multiplied out.
    next_addr   = pix_addr + ADDR_W'(2);
  end

  // Auto-refresh counter: restarts at every frame launch, saturates at the period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt <= '0;
    end else if (REFRESH_CYCLES == 0) begin
      ref_cnt <= '0;
    end else if (launch) begin
      ref_cnt <= '0;
    end else if (ref_cnt != REF_MAX) begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      pix_addr   <= '0;
      spram_addr <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            pix_addr   <= base_addr;
            spram_addr <= base_addr;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= LO;
          end
        end
        LO: begin
          spram_addr <= pix_addr + 1'b1;
          state      <= HI;
        end
        HI: begin
          pix_data[15:0] <= spram_dout;
          state          <= CAP;
        end
        CAP: begin
          pix_data[23:16] <= spram_dout[7:0];
          pix_valid       <= 1'b1;
          pix_last        <= (idx == LAST_IDX);
          state           <= PRESENT;
        end
        PRESENT: begin
          if (accept) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
            if (idx == LAST_IDX) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              idx        <= idx + 1'b1;
              pix_addr   <= next_addr;
              spram_addr <= next_addr;
              state      <= LO;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
